// File: rtl/btn_led_seq_ctrl.sv
// Push-button LED sequencer: sampled button edges drive a run/pause FSM and a
// prescaled step that counts or rotates a WIDTH-bit LED pattern.
module btn_led_seq_ctrl #(
    parameter int WIDTH    = 8,
    parameter int TICK_DIV = 25_000_000
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_btn_run,
    input  logic             i_btn_mode,
    input  logic             i_clr,
    output logic [WIDTH-1:0] o_led,
    output logic [1:0]       o_mode,
    output logic             o_run,
    output logic             o_tick
);

    localparam int              PW         = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [1:0]      MODE_COUNT = 2'b00;
    localparam logic [1:0]      MODE_SHL   = 2'b01;
    localparam logic [1:0]      MODE_SHR   = 2'b10;
    localparam logic [WIDTH-1:0] LED_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10
    } state_t;

    function automatic logic [WIDTH-1:0] step_pattern(input logic [WIDTH-1:0] cur,
                                                      input logic [1:0]       mode);
        logic [WIDTH-1:0] nxt;
        case (mode)
            MODE_COUNT: nxt = cur + WIDTH'(1);
            MODE_SHL:   nxt = {cur[WIDTH-2:0], cur[WIDTH-1]};
            MODE_SHR:   nxt = {cur[0], cur[WIDTH-1:1]};
            default:    nxt = cur;
        endcase
        return nxt;
    endfunction

    logic             run_s0_q, run_s1_q, mode_s0_q, mode_s1_q;
    logic             run_pulse_s, mode_pulse_s;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] led_q, led_d;
    logic [1:0]       mode_q, mode_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             tick_q, tick_d;
    logic             run_q, run_d;

    assign run_pulse_s  = run_s0_q & ~run_s1_q;
    assign mode_pulse_s = mode_s0_q & ~mode_s1_q;

    // Button samplers plus all architectural state, synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            run_s0_q  <= 1'b0;
            run_s1_q  <= 1'b0;
            mode_s0_q <= 1'b0;
            mode_s1_q <= 1'b0;
            state_q   <= ST_IDLE;
            led_q     <= '0;
            mode_q    <= MODE_COUNT;
            presc_q   <= '0;
            tick_q    <= 1'b0;
            run_q     <= 1'b0;
        end else begin
            run_s0_q  <= i_btn_run;
            run_s1_q  <= run_s0_q;
            mode_s0_q <= i_btn_mode;
            mode_s1_q <= mode_s0_q;
            state_q   <= state_d;
            led_q     <= led_d;
            mode_q    <= mode_d;
            presc_q   <= presc_d;
            tick_q    <= tick_d;
            run_q     <= run_d;
        end
    end

    // FSM next state, prescaler, pattern step; clear outranks the run pulse.
    always_comb begin
        state_d = state_q;
        led_d   = led_q;
        presc_d = presc_q;
        tick_d  = 1'b0;
        if (i_clr) begin
            state_d = ST_IDLE;
            led_d   = '0;
            presc_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    presc_d = '0;
                    if (run_pulse_s) begin
                        state_d = ST_RUN;
                        led_d   = (mode_q == MODE_COUNT) ? '0 : LED_ONE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    // A pause request wins over a coincident wrap: no step, no tick.
                    if (run_pulse_s) begin
                        state_d = ST_PAUSE;
                    end else if (presc_q == PRESC_LAST) begin
                        presc_d = '0;
                        tick_d  = 1'b1;
                        led_d   = step_pattern(led_q, mode_q);
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                ST_PAUSE: begin
                    if (run_pulse_s) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_PAUSE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    led_d   = '0;
                    presc_d = '0;
                end
            endcase
        end
    end

    // Mode rotation, independent of FSM state and of clear.
    always_comb begin
        mode_d = mode_q;
        if (mode_pulse_s) begin
            case (mode_q)
                MODE_COUNT: mode_d = MODE_SHL;
                MODE_SHL:   mode_d = MODE_SHR;
                default:    mode_d = MODE_COUNT;
            endcase
        end else begin
            mode_d = mode_q;
        end
    end

    assign run_d  = (state_d == ST_RUN);
    assign o_led  = led_q;
    assign o_mode = mode_q;
    assign o_run  = run_q;
    assign o_tick = tick_q;

endmodule
